// File: rtl/thermo_enc_pkg.sv
// Shared types and elaboration helpers for the thermometer accumulate encoder.
// Width helpers are plain int functions so parameter defaults can be derived from them.
package thermo_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Decoder works on a fixed maximum word width; callers pass the live width.
  localparam int MAX_THERM_W = 64;
  localparam int DEC_CNT_W   = 7;

  typedef struct packed {
    logic                 err;
    logic [DEC_CNT_W-1:0] cnt;
  } dec_t;

  function automatic int cnt_width(input int therm_w);
    return $clog2(therm_w + 1);
  endfunction

  function automatic int wpow(input int weight, input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * weight;
    return p;
  endfunction

  function automatic int sum_width(input int num_ch, input int therm_w, input int weight);
    int s;
    s = 0;
    for (int i = 0; i < num_ch; i++) s = s + wpow(weight, i);
    return $clog2(therm_w * s + 1);
  endfunction

  // Valid codes are ones packed from the MSB; any one below a zero is a bubble.
  function automatic dec_t therm_decode(input logic [MAX_THERM_W-1:0] word, input int width);
    dec_t d;
    logic seen_zero;
    d = '0;
    seen_zero = 1'b0;
    for (int i = MAX_THERM_W - 1; i >= 0; i--) begin
      if (i < width) begin
        if (word[i]) begin
          if (seen_zero) d.err = 1'b1;
          else d.cnt = d.cnt + DEC_CNT_W'(1);
        end else begin
          seen_zero = 1'b1;
        end
      end
    end
    if (d.err) d.cnt = '0;
    return d;
  endfunction

endpackage

// File: rtl/thermo_ch_decode.sv
// Single-channel thermometer decoder: ones count, or zero plus err on a bubble.
module thermo_ch_decode
  import thermo_enc_pkg::*;
#(
  parameter int THERM_W = 8,
  parameter int CNT_W   = cnt_width(THERM_W)
) (
  input  logic [THERM_W-1:0] word_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               err_o
);

  if (THERM_W > MAX_THERM_W) begin : g_width_check
    $error("THERM_W exceeds decoder maximum");
  end

  dec_t dec;

  always_comb begin
    dec   = therm_decode(MAX_THERM_W'(word_i), THERM_W);
    cnt_o = CNT_W'(dec.cnt);
    err_o = dec.err;
  end

endmodule

// File: rtl/thermo_accum_encoder.sv
// Multi-channel thermometer-to-binary encoder with optional saturating beat accumulation.
// state | meaning
// IDLE  | waiting for the first beat of a group
// ACC   | accumulating remaining beats of a group
// HOLD  | result presented on the output until consumed
module thermo_accum_encoder
  import thermo_enc_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int THERM_W = 8,
  parameter int WEIGHT  = 8,
  parameter int LEN_W   = 8,
  parameter int ACC_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NUM_CH*THERM_W-1:0] therm_i,
  input  logic                      acc_en_i,
  input  logic [LEN_W-1:0]          acc_len_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ACC_W-1:0]          data_o,
  output logic                      code_err_o,
  output logic                      sat_o
);

  localparam int CNT_W = cnt_width(THERM_W);
  localparam int SUM_W = sum_width(NUM_CH, THERM_W, WEIGHT);

  if (ACC_W < SUM_W) begin : g_acc_w_check
    $error("ACC_W must be at least SUM_W");
  end

  logic [CNT_W-1:0]  ch_cnt [NUM_CH];
  logic [NUM_CH-1:0] ch_err;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    thermo_ch_decode #(
      .THERM_W(THERM_W),
      .CNT_W  (CNT_W)
    ) u_dec (
      .word_i(therm_i[(NUM_CH-k)*THERM_W-1 -: THERM_W]),
      .cnt_o (ch_cnt[k]),
      .err_o (ch_err[k])
    );
  end

  logic [SUM_W-1:0] beat_val;
  logic             beat_err;

  always_comb begin
    beat_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      beat_val = beat_val + SUM_W'(int'(ch_cnt[k]) * wpow(WEIGHT, NUM_CH - 1 - k));
    end
    beat_err = |ch_err;
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W:0]   cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q, sat_q;
  logic [ACC_W-1:0] data_q;
  logic             code_err_q, sat_out_q;

  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             acc_carry;
  logic [LEN_W:0]   cnt_inc;
  logic             acc_last;
  logic [LEN_W-1:0] len_eff;

  assign acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(beat_val);
  assign acc_carry = acc_sum[ACC_W];
  assign acc_next  = acc_carry ? '1 : acc_sum[ACC_W-1:0];
  assign cnt_inc   = cnt_q + (LEN_W+1)'(1);
  assign acc_last  = (cnt_inc == {1'b0, len_q});
  assign len_eff   = (acc_len_i == '0) ? LEN_W'(1) : acc_len_i;

  logic accept, first_beat, pass_done, acc_beat, acc_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (first_beat) state_d = pass_done ? HOLD : ACC;
      ACC:  if (acc_done) state_d = HOLD;
      HOLD: begin
        if (first_beat)       state_d = pass_done ? HOLD : ACC;
        else if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A beat taken while HOLD pops counts as the next group's first beat.
  always_comb begin
    out_valid_o = (state_q == HOLD);
    in_ready_o  = !out_valid_o || out_ready_i;
    accept      = in_valid_i && in_ready_o;
    first_beat  = accept && (state_q == IDLE || state_q == HOLD);
    pass_done   = first_beat && (!acc_en_i || len_eff == LEN_W'(1));
    acc_beat    = accept && (state_q == ACC);
    acc_done    = acc_beat && acc_last;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
      data_q     <= '0;
      code_err_q <= 1'b0;
      sat_out_q  <= 1'b0;
    end else if (first_beat) begin
      acc_q <= ACC_W'(beat_val);
      err_q <= beat_err;
      sat_q <= 1'b0;
      cnt_q <= (LEN_W+1)'(1);
      len_q <= len_eff;
      if (pass_done) begin
        data_q     <= ACC_W'(beat_val);
        code_err_q <= beat_err;
        sat_out_q  <= 1'b0;
      end
    end else if (acc_beat) begin
      acc_q <= acc_next;
      err_q <= err_q | beat_err;
      sat_q <= sat_q | acc_carry;
      cnt_q <= cnt_inc;
      if (acc_done) begin
        data_q     <= acc_next;
        code_err_q <= err_q | beat_err;
        sat_out_q  <= sat_q | acc_carry;
      end
    end
  end

  assign data_o     = data_q;
  assign code_err_o = code_err_q;
  assign sat_o      = sat_out_q;

endmodule

// File: tb/tb_thermo_accum_encoder.sv
// Scoreboard bench: a 16-bit and an 8-bit accumulator build share stimulus and
// are checked against a group-level arithmetic reference model.
module tb_thermo_accum_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] therm;
  logic        acc_en;
  logic [7:0]  acc_len;
  logic        out_ready = 1'b1;

  logic        in_ready, ov, cerr, sat;
  logic [15:0] data;
  logic        in_ready8, ov8, cerr8, sat8;
  logic [7:0]  data8;

  always #5 clk = ~clk;

  thermo_accum_encoder dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .therm_i(therm), .acc_en_i(acc_en), .acc_len_i(acc_len),
    .out_valid_o(ov), .out_ready_i(out_ready), .data_o(data),
    .code_err_o(cerr), .sat_o(sat)
  );

  thermo_accum_encoder #(.ACC_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready8),
    .therm_i(therm), .acc_en_i(acc_en), .acc_len_i(acc_len),
    .out_valid_o(ov8), .out_ready_i(out_ready), .data_o(data8),
    .code_err_o(cerr8), .sat_o(sat8)
  );

  typedef struct {
    int d16;
    int s16;
    int d8;
    int s8;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   pops = 0;
  bit   front_seen = 0;

  int      grp_left = 0;
  longint  grp_sum = 0;
  bit      grp_err = 0;

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #1;
    if (ready_mode == 0)      out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else                      out_ready = 1'b0;
  end

  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] tcode(input int n);
    int g;
    g = 256 - (1 << (8 - n));
    return 8'(g);
  endfunction

  function automatic int ref_digit(input logic [7:0] w, output bit e);
    int n;
    n = $countones(w);
    if (w == tcode(n)) begin
      e = 0;
      return n;
    end
    e = 1;
    return 0;
  endfunction

  function automatic logic [7:0] rand_word();
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    return tcode($urandom_range(0, 8));
  endfunction

  task automatic model_accept(input logic [15:0] t, input bit en, input logic [7:0] l);
    bit   e0, e1;
    int   v0, v1, v;
    exp_t x;
    v0 = ref_digit(t[15:8], e0);
    v1 = ref_digit(t[7:0], e1);
    v  = v0 * 8 + v1;
    if (grp_left == 0) begin
      grp_left = en ? ((l == 0) ? 1 : int'(l)) : 1;
      grp_sum  = v;
      grp_err  = e0 | e1;
    end else begin
      grp_sum = grp_sum + v;
      grp_err = grp_err | e0 | e1;
    end
    grp_left--;
    if (grp_left == 0) begin
      x.d16 = (grp_sum > 65535) ? 65535 : int'(grp_sum);
      x.s16 = (grp_sum > 65535) ? 1 : 0;
      x.d8  = (grp_sum > 255) ? 255 : int'(grp_sum);
      x.s8  = (grp_sum > 255) ? 1 : 0;
      x.err = grp_err ? 1 : 0;
      x.cyc = cyc + 1;
      sb.push_back(x);
    end
  endtask

  task automatic beat(input logic [15:0] t, input bit en, input logic [7:0] l, output int stalls);
    bit done;
    done = 0;
    stalls = 0;
    in_valid = 1'b1;
    therm = t;
    acc_en = en;
    acc_len = l;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        model_accept(t, en, l);
        done = 1;
      end else if (stalls >= 200) begin
        compared++;
        mismatched++;
        $display("FAIL accept_timeout: got no in_ready for %0d cycles, required acceptance", stalls);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_model();
    sb.delete();
    front_seen = 0;
    grp_left = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ov === 1'b1 || ov8 === 1'b1)) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got data %0d, required no output", data);
      end else begin
        chk("out_valid16", int'(ov), 1);
        chk("out_valid8", int'(ov8), 1);
        chk("data16", int'(data), sb[0].d16);
        chk("sat16", int'(sat), sb[0].s16);
        chk("code_err16", int'(cerr), sb[0].err);
        chk("data8", int'(data8), sb[0].d8);
        chk("sat8", int'(sat8), sb[0].s8);
        chk("code_err8", int'(cerr8), sb[0].err);
        if (!front_seen) begin
          chk("latency_cycle", cyc, sb[0].cyc);
          front_seen = 1;
        end
        if (out_ready === 1'b1) begin
          void'(sb.pop_front());
          front_seen = 0;
          pops++;
        end
      end
    end
  end

  initial begin
    int st;
    int start;
    rst_n = 1'b0;
    in_valid = 1'b0;
    therm = '0;
    acc_en = 1'b0;
    acc_len = '0;

    #23;
    chk("reset_out_valid", int'(ov), 0);
    chk("reset_data", int'(data), 0);
    chk("reset_code_err", int'(cerr), 0);
    chk("reset_sat", int'(sat), 0);
    chk("reset_out_valid8", int'(ov8), 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("in_ready_after_reset", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // pass mode: 3*8 + 5 = 29
    beat({8'b11100000, 8'b11111000}, 0, 8'd0, st);
    idle(2);
    // bubble code then a clean zero word
    beat({8'b10100000, 8'hFF}, 0, 8'd0, st);
    beat(16'h0000, 0, 8'd0, st);
    idle(2);

    // accumulate 4 x 29 with gaps; later beats carry different mode fields
    beat({8'b11100000, 8'b11111000}, 1, 8'd4, st);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      beat({8'b11100000, 8'b11111000}, 0, 8'd1, st);
      idle(1 + i);
    end
    idle(2);

    // backpressure
    ready_mode = 2;
    beat({8'b11100000, 8'b11111000}, 0, 8'd0, st);
    fork
      beat(16'hFF00, 0, 8'd0, st);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("in_ready_backpressure", int'(in_ready), 0);
        end
        ready_mode = 0;
      end
    join
    idle(3);

    // back-to-back pass beats
    start = pops;
    for (int i = 0; i < 10; i++) begin
      beat({tcode($urandom_range(0, 8)), tcode($urandom_range(0, 8))}, 0, 8'($urandom), st);
      chk("b2b_stall", st, 0);
    end
    idle(2);
    chk("b2b_outputs", pops - start, 10);

    // saturation and len=0
    for (int i = 0; i < 4; i++) beat(16'hFFFF, 1, 8'd4, st);
    idle(2);
    beat(16'hFFFF, 1, 8'd0, st);
    idle(2);
    for (int i = 0; i < 255; i++) beat(16'hFFFF, 1, 8'd255, st);
    idle(2);

    // reset in the middle of an accumulation group
    beat({8'b11100000, 8'b11111000}, 1, 8'd4, st);
    beat({8'b11100000, 8'b11111000}, 1, 8'd4, st);
    #3 rst_n = 1'b0;
    flush_model();
    #1 chk("out_valid_reset_acc", int'(ov), 0);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat({8'h00, 8'b11111000}, 1, 8'd1, st);
    idle(2);

    // reset while a result is held under backpressure
    ready_mode = 2;
    beat({8'b11000000, 8'h00}, 0, 8'd0, st);
    idle(1);
    #3 rst_n = 1'b0;
    flush_model();
    #1 chk("out_valid_reset_hold", int'(ov), 0);
    #7 rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("out_valid_after_hold_reset", int'(ov), 0);
    @(posedge clk);
    #1;

    // randomized traffic with random consumer stalls
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      beat({rand_word(), rand_word()}, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)), st);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    ready_mode = 0;
    idle(1);
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
    chk("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/thermo_accum_encoder.md
Name: thermo_accum_encoder

Overview:
Parametrised successor to the two-channel thermometer-to-binary output encoder in the output buffer path. It decodes NUM_CH thermometer-coded sense-amp/ADC words and combines them as weighted digits into one binary value. It can optionally accumulate a programmable number of beats before emitting a result. Valid/ready handshakes sit on both sides, and the output is registered; it feeds the output buffer FIFO / bus readback.

Parameters:
NUM_CH, 2, number of thermometer channels; channel 0 is the most significant digit
THERM_W, 8, bits per thermometer word (ones packed from MSB)
WEIGHT, 8, radix between adjacent channels (value = sum cnt[k]*WEIGHT^(NUM_CH-1-k))
LEN_W, 8, width of accumulate-length field
ACC_W, 16, accumulator/output width; must be >= SUM_W (checked by elaboration assertion)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o
therm_i  in  NUM_CH*THERM_W  channel k at bits [(NUM_CH-k)*THERM_W-1 -: THERM_W]
acc_en_i  in  1  sampled on the first beat of a group; 1 = accumulate mode
acc_len_i  in  LEN_W  beats per group, sampled with acc_en_i; 0 is treated as 1
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when out_valid_o && out_ready_i
data_o  out  ACC_W  summed or combined value
code_err_o  out  1  a non-thermometer code was seen in any beat of the group
sat_o  out  1  accumulator saturated in the group

Behaviour:
- Reset: the block is held in asynchronous reset while rst_ni=0. Outputs: out_valid_o=0, data_o=0, code_err_o=0, sat_o=0. The FSM goes to IDLE, and the beat counter and accumulator clear. in_ready_o=1 once reset is released.
- Decode (combinational per channel):
  - A valid code is ones contiguous from the MSB: 0 to THERM_W ones, giving cnt = number of ones.
  - Any other pattern gives cnt=0 and sets that beat's err bit.
- Combine: beat_val = sum of cnt[k]*WEIGHT^(NUM_CH-1-k), computed at SUM_W = clog2(THERM_W*sum WEIGHT^i + 1). For the defaults, max = 8*8+8 = 72 and SUM_W = 7.
- Handshake: in_ready_o = !out_valid_o || out_ready_i in every state.
- FSM states are IDLE, ACC and HOLD.
- IDLE, beat accepted:
  - The first beat latches mode and length (len = max(acc_len_i,1)) and sets acc = beat_val, err = beat err, cnt = 1.
  - If pass mode or len=1: next state HOLD. data_o = beat_val zero-extended, out_valid_o=1 one cycle after acceptance.
  - Otherwise: next state ACC.
- ACC, beat accepted:
  - acc = sat_add(acc, beat_val); err |= beat err; cnt++.
  - When cnt reaches len: data_o/code_err_o/sat_o load, out_valid_o=1 next cycle, next state HOLD.
  - acc_en_i and acc_len_i are ignored in ACC.
- HOLD:
  - The output stays stable while out_valid_o && !out_ready_i.
  - On out_ready_i the result is consumed and the state goes to IDLE.
  - A beat accepted in the same cycle as that pop is treated as the IDLE first beat. This gives back-to-back pass-mode throughput of 1 beat/cycle.
- Saturation: an accumulator sum above 2^ACC_W-1 clamps to 2^ACC_W-1, and sat_o=1 is sticky for the group.
- Latency: 1 cycle from the last accepted beat to out_valid_o.
- No in_valid_i: state is held, and there is no timeout.
- Reset mid-group: the partial accumulation is discarded and no output is produced.
- Group boundary: the beat counter is LEN_W+1 bits, so len=2^LEN_W-1 cannot wrap.

Decomposition:
- Package thermo_enc_pkg holds:
  - state_e enum (IDLE, ACC, HOLD);
  - function therm_decode(word) -> {err, cnt};
  - localparams CNT_W = clog2(THERM_W+1) and SUM_W derivation.
- One sub-module, thermo_ch_decode: a single-channel decoder instantiated NUM_CH times via generate. The combine, FSM and accumulator stay in the top.

Test Plan:
- Pass mode: therm_i = {8'b11100000, 8'b11111000}, acc_en_i=0, out_ready_i=1 -> one cycle later out_valid_o=1, data_o=29, code_err_o=0.
- Bubble code: ch0 = 8'b10100000, ch1 = 8'hFF -> data_o=8, code_err_o=1. Next clean beat 8'h00/8'h00 -> data_o=0, code_err_o=0.
- Accumulate: acc_en_i=1, acc_len_i=4, four beats of value 29 with gaps on in_valid_i -> a single output data_o=116, 1 cycle after the 4th beat. No output earlier.
- Backpressure: hold out_ready_i=0 for 5 cycles while driving beats.
  - Expect in_ready_o=0, and data_o stable at its first value.
  - Release -> results arrive in order with none lost or duplicated.
  - Back-to-back 10 pass beats with out_ready_i=1 -> 10 outputs in 10 consecutive cycles.
- Saturation (ACC_W=8 build): acc_len_i=4, four beats of 72 -> data_o=255, sat_o=1. acc_len_i=0 -> treated as 1 beat.
- Reset mid-ACC: after 2 of 4 beats, pulse rst_ni low asynchronously (not clock-aligned) -> out_valid_o=0 immediately. A new group of len 1 with value 5 -> data_o=5, sat_o=0, code_err_o=0.
